// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between exception status, queued loads and ALU results.
// Optional pending-write compare enabled by defining WB_PENDING_CHECK_EN.
module regfile_wb_arbiter #(
  parameter int unsigned LQ_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        exc_valid,
  input  logic [31:0] exc_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_reg,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic        pend_hit_a,
  output logic        pend_hit_b,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int unsigned PTR_W  = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned AGE_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [REG_W-1:0] EXC_REG = 5'd30;

  logic [REG_W-1:0]  lq_reg  [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  lq_count;
  logic [AGE_W-1:0]  age;

  logic              lq_empty;
  logic              lq_full;
  logic              alu_starved;
  logic              lq_push;
  logic              sel_exc;
  logic              sel_alu;
  logic              sel_ld;
  logic              grant_any;
  logic [REG_W-1:0]  grant_reg;
  logic [DATA_W-1:0] grant_data;

  assign lq_empty    = (lq_count == '0);
  assign lq_full     = (lq_count == CNT_W'(LQ_DEPTH));
  assign alu_starved = (age == AGE_W'(STARVE_LIMIT));
  assign lq_push     = ld_valid && !lq_full;
  assign ld_ready    = !lq_full;
  assign alu_ready   = reset_n && sel_alu;

  // Fixed priority: exception, starved ALU, load head, ALU.
  always_comb begin
    sel_exc    = 1'b0;
    sel_alu    = 1'b0;
    sel_ld     = 1'b0;
    grant_any  = 1'b0;
    grant_reg  = '0;
    grant_data = '0;
    if (exc_valid) begin
      sel_exc    = 1'b1;
      grant_any  = 1'b1;
      grant_reg  = EXC_REG;
      grant_data = exc_data;
    end else if (alu_valid && alu_starved) begin
      sel_alu    = 1'b1;
      grant_any  = 1'b1;
      grant_reg  = alu_reg;
      grant_data = alu_data;
    end else if (!lq_empty) begin
      sel_ld     = 1'b1;
      grant_any  = 1'b1;
      grant_reg  = lq_reg[rd_ptr];
      grant_data = lq_data[rd_ptr];
    end else if (alu_valid) begin
      sel_alu    = 1'b1;
      grant_any  = 1'b1;
      grant_reg  = alu_reg;
      grant_data = alu_data;
    end
  end

  // r0 grants are consumed but never raise the write enable.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= grant_any && (grant_reg != '0);
      if (grant_any) begin
        ctrl_writeReg <= grant_reg;
        data_writeReg <= grant_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lq_count <= '0;
    end else begin
      if (lq_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (sel_ld) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({lq_push, sel_ld})
        2'b10:   lq_count <= lq_count + CNT_W'(1);
        2'b01:   lq_count <= lq_count - CNT_W'(1);
        default: lq_count <= lq_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (lq_push) begin
      lq_reg[wr_ptr]  <= ld_reg;
      lq_data[wr_ptr] <= ld_data;
    end
  end

  // Counts consecutive denied ALU cycles; any idle or granted cycle clears it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      age <= '0;
    end else if (!alu_valid || sel_alu) begin
      age <= '0;
    end else if (!alu_starved) begin
      age <= age + AGE_W'(1);
    end
  end

`ifdef WB_PENDING_CHECK_EN
  logic hit_a;
  logic hit_b;

  // Match against live queue entries and the write currently on the port.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int k = 0; k < int'(LQ_DEPTH); k++) begin
      if (CNT_W'(k) < lq_count) begin
        if (lq_reg[rd_ptr + PTR_W'(k)] == rd_addr_a) hit_a = 1'b1;
        if (lq_reg[rd_ptr + PTR_W'(k)] == rd_addr_b) hit_b = 1'b1;
      end
    end
    if (ctrl_writeEnable && (ctrl_writeReg == rd_addr_a)) hit_a = 1'b1;
    if (ctrl_writeEnable && (ctrl_writeReg == rd_addr_b)) hit_b = 1'b1;
  end

  assign pend_hit_a = reset_n && (rd_addr_a != '0) && hit_a;
  assign pend_hit_b = reset_n && (rd_addr_b != '0) && hit_b;
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^{rd_addr_a, rd_addr_b};
  assign pend_hit_a     = 1'b0;
  assign pend_hit_b     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based writeback model.
module tb_regfile_wb_arbiter;

  localparam int unsigned LQ_DEPTH     = 2;
  localparam int unsigned STARVE_LIMIT = 3;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_data = '0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_reg = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic        pend_hit_a;
  logic        pend_hit_b;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        q[$];
  int          age = 0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_reg = '0;
  logic [31:0] exp_data = '0;

  regfile_wb_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .exc_valid(exc_valid), .exc_data(exc_data),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .pend_hit_a(pend_hit_a), .pend_hit_b(pend_hit_b),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: check last registered write, drive, check handshakes, advance model.
  task automatic cycle(input logic ev, input logic [31:0] ed,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ldat,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic [4:0] ra, input logic [4:0] rb);
    ent_t        e;
    logic        m_ldr;
    logic        m_alur;
    logic        m_pa;
    logic        m_pb;
    logic        g;
    logic [4:0]  gr;
    logic [31:0] gd;
    @(negedge clock);
    chk("write_en", 32'(ctrl_writeEnable), 32'(exp_we));
    if (exp_we) begin
      chk("write_reg", 32'(ctrl_writeReg), 32'(exp_reg));
      chk("write_data", data_writeReg, exp_data);
    end
    exc_valid = ev; exc_data = ed;
    ld_valid = lv; ld_reg = lr; ld_data = ldat;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
    m_ldr = (q.size() < int'(LQ_DEPTH));
    m_pa = 1'b0;
    m_pb = 1'b0;
`ifdef WB_PENDING_CHECK_EN
    foreach (q[i]) begin
      if (q[i].r == ra) m_pa = 1'b1;
      if (q[i].r == rb) m_pb = 1'b1;
    end
    if (exp_we && exp_reg == ra) m_pa = 1'b1;
    if (exp_we && exp_reg == rb) m_pb = 1'b1;
    if (ra == 5'd0) m_pa = 1'b0;
    if (rb == 5'd0) m_pb = 1'b0;
`endif
    g = 1'b0; gr = '0; gd = '0; m_alur = 1'b0;
    if (ev) begin
      g = 1'b1; gr = 5'd30; gd = ed;
    end else if (av && age == int'(STARVE_LIMIT)) begin
      g = 1'b1; gr = ar; gd = ad; m_alur = 1'b1;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      g = 1'b1; gr = e.r; gd = e.d;
    end else if (av) begin
      g = 1'b1; gr = ar; gd = ad; m_alur = 1'b1;
    end
    chk("ld_ready", 32'(ld_ready), 32'(m_ldr));
    chk("alu_ready", 32'(alu_ready), 32'(m_alur));
    chk("pend_hit_a", 32'(pend_hit_a), 32'(m_pa));
    chk("pend_hit_b", 32'(pend_hit_b), 32'(m_pb));
    if (lv && m_ldr) begin
      e.r = lr; e.d = ldat;
      q.push_back(e);
    end
    if (!av || m_alur) age = 0;
    else if (age < int'(STARVE_LIMIT)) age++;
    exp_we = g && (gr != 5'd0);
    if (g) begin
      exp_reg = gr;
      exp_data = gd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Hold reset with an ALU request pending to show that reset masks the handshake.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    exc_valid = 1'b0; ld_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h55;
    rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("rst_alu_ready", 32'(alu_ready), 32'd0);
      chk("rst_pend_a", 32'(pend_hit_a), 32'd0);
    end
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_reg", 32'(ctrl_writeReg), 32'd0);
    chk("rst_data", data_writeReg, 32'd0);
    reset_n = 1'b1;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    q.delete();
    age = 0;
    exp_we = 1'b0; exp_reg = '0; exp_data = '0;
  endtask

  initial begin
    do_reset(5);

    // Reset release then a single ALU write.
    cycle(0, 0, 0, 0, 0, 1, 5, 32'h7, 0, 0);
    chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    idle(1);
    chk("post_rst_we", 32'(ctrl_writeEnable), 32'd1);
    chk("post_rst_reg", 32'(ctrl_writeReg), 32'd5);
    chk("post_rst_data", data_writeReg, 32'h7);
    idle(1);

    // Priority: exception, then load, then ALU.
    cycle(1, 32'h1, 1, 3, 32'hDEADBEEF, 1, 4, 32'h11, 0, 0);
    chk("prio_alu_stall", 32'(alu_ready), 32'd0);
    cycle(0, 0, 0, 0, 0, 1, 4, 32'h11, 0, 0);
    chk("prio_w1_reg", 32'(ctrl_writeReg), 32'd30);
    chk("prio_w1_data", data_writeReg, 32'h1);
    cycle(0, 0, 0, 0, 0, 1, 4, 32'h11, 0, 0);
    chk("prio_w2_reg", 32'(ctrl_writeReg), 32'd3);
    chk("prio_w2_data", data_writeReg, 32'hDEADBEEF);
    chk("prio_alu_grant", 32'(alu_ready), 32'd1);
    idle(1);
    chk("prio_w3_reg", 32'(ctrl_writeReg), 32'd4);
    chk("prio_w3_data", data_writeReg, 32'h11);
    idle(1);

    // Queue full while exceptions block pops.
    cycle(1, 32'hA, 1, 10, 32'hA0, 0, 0, 0, 0, 0);
    cycle(1, 32'hB, 1, 11, 32'hB0, 0, 0, 0, 0, 0);
    cycle(1, 32'hC, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    cycle(0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
    chk("full_no_popthru", 32'(ld_ready), 32'd0);
    cycle(0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
    chk("full_q1_reg", 32'(ctrl_writeReg), 32'd10);
    idle(1);
    chk("full_q2_reg", 32'(ctrl_writeReg), 32'd11);
    idle(1);
    chk("full_q3_reg", 32'(ctrl_writeReg), 32'd12);
    chk("full_q3_data", data_writeReg, 32'hC0);
    idle(1);

    // Starvation: ALU promoted after exactly three denied cycles.
    cycle(0, 0, 1, 1, 32'h100, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 5'(2 + i), 32'(i), 1, 7, 32'h77, 0, 0);
      chk("starve_ready", 32'(alu_ready), (i == 3) ? 32'd1 : 32'd0);
    end
    idle(1);
    chk("starve_reg", 32'(ctrl_writeReg), 32'd7);
    chk("starve_data", data_writeReg, 32'h77);
    idle(3);

    // r0 writes are consumed silently.
    cycle(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    idle(1);
    idle(1);
    chk("r0_ld_we", 32'(ctrl_writeEnable), 32'd0);
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, 0);
    chk("r0_alu_ready", 32'(alu_ready), 32'd1);
    idle(1);
    chk("r0_alu_we", 32'(ctrl_writeEnable), 32'd0);
    idle(1);

`ifdef WB_PENDING_CHECK_EN
    cycle(1, 32'h5, 1, 9, 32'h99, 0, 0, 0, 9, 0);
    chk("pend_before_push", 32'(pend_hit_a), 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("pend_queued", 32'(pend_hit_a), 32'd1);
    chk("pend_b_r0", 32'(pend_hit_b), 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("pend_writing", 32'(pend_hit_a), 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("pend_retired", 32'(pend_hit_a), 32'd0);
    idle(1);
`endif

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(2);
      cycle(($urandom_range(0, 7) == 0), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
